// File: rtl/booth_radix4_if.sv
// Operand/result bundle for the radix-4 Booth multiplier.
// The master drives the operands and the slave publishes the product.
interface booth_radix4_if;
  logic [15:0] x;
  logic [15:0] y;
  logic [31:0] out;

  modport master (output x, output y, input out);
  modport slave  (input x, input y, output out);
endinterface

// File: rtl/booth_radix4.sv
// Free-running sequential signed 16x16 multiplier, one radix-4 Booth digit per clock.
// The period is LOAD, eight RUN cycles, then DONE; a new product is published every 10 clocks.
module booth_radix4 (
  input  logic           clk,
  input  logic           reset,
  booth_radix4_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [16:0] mplier_q, mplier_d;   // {y, y[-1]}
  logic [31:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] out_q, out_d;

  logic [4:0]  trip_idx;
  logic [2:0]  triplet;
  logic [17:0] mc18;
  logic [17:0] pp18;
  logic [31:0] pp32;

  // Digit i uses bits {y[2i+1], y[2i], y[2i-1]}, which sit at [2i+2:2i] once y[-1] is appended.
  assign trip_idx = {1'b0, cnt_q, 1'b0};
  assign triplet  = mplier_q[trip_idx +: 3];
  assign mc18     = {{2{mcand_q[15]}}, mcand_q};

  always_comb begin
    pp18 = 18'd0;
    case (triplet)
      3'b001, 3'b010: pp18 = mc18;
      3'b011:         pp18 = mc18 << 1;
      3'b100:         pp18 = -(mc18 << 1);
      3'b101, 3'b110: pp18 = -mc18;
      default:        pp18 = 18'd0;
    endcase
  end

  assign pp32 = {{14{pp18[17]}}, pp18} << {cnt_q, 1'b0};

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    case (state_q)
      LOAD: begin
        mcand_d  = bus.x;
        mplier_d = {bus.y, 1'b0};
        acc_d    = 32'd0;
        cnt_d    = 3'd0;
        state_d  = RUN;
      end
      RUN: begin
        acc_d = acc_q + pp32;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_d   = acc_q;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      mcand_q  <= 16'd0;
      mplier_q <= 17'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 3'd0;
      out_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_booth_radix4.sv
// Scoreboard bench for booth_radix4: each operand pair's product is queued when driven
// and checked against out after the tenth edge of its period.
module tb_booth_radix4;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic [31:0] exp_q[$];
  logic [31:0] last_out;

  booth_radix4_if bus ();

  booth_radix4 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: out=0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: out=0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa * sb);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: scoreboard empty, out=0x%08h", tag, bus.out);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.out, e);
      last_out = e;
    end
  endtask

  // Drive one operand pair for a full period: expected is either a given constant or the model.
  task automatic run_period(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                            input logic use_const, input logic [31:0] cexp, input logic verbose);
    bus.x = xv;
    bus.y = yv;
    exp_q.push_back(use_const ? cexp : ref_mul(xv, yv));
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (verbose && e == 9) chk({tag, "_hold"}, bus.out, last_out);
    end
    tick();
    pop_check(tag);
  endtask

  logic [15:0] dx [5] = '{16'hFFFF, 16'h0007, 16'h8000, 16'h7FFF, 16'h0000};
  logic [15:0] dy [5] = '{16'h0001, 16'hFFFD, 16'h8000, 16'h8000, 16'h8000};
  logic [31:0] dp [5] = '{32'hFFFFFFFF, 32'hFFFFFFEB, 32'h40000000, 32'hC0008000, 32'h00000000};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_out     = 32'd0;
    reset        = 1'b1;
    bus.x        = 16'h0003;
    bus.y        = 16'h0004;
    tick();
    chk("reset", bus.out, 32'd0);
    reset = 1'b0;

    // Basic case: out stays 0 for edges 1..9, then 12 after edge 10
    exp_q.push_back(32'h0000000C);
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 1 || e == 9) chk($sformatf("basic_e%0d", e), bus.out, 32'd0);
    end
    tick();
    pop_check("basic");
    // Same operands again: product persists across the next period
    run_period("basic_again", 16'h0003, 16'h0004, 1'b1, 32'h0000000C, 1'b1);

    for (int i = 0; i < 5; i++) begin
      run_period($sformatf("directed%0d", i), dx[i], dy[i], 1'b1, dp[i], 1'b1);
    end

    // Operand stability: operands change mid-RUN and only affect the next period
    bus.x = 16'h0003;
    bus.y = 16'h0004;
    exp_q.push_back(32'h0000000C);
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 4) begin
        bus.x = 16'h0005;
        bus.y = 16'h0006;
      end
    end
    tick();
    pop_check("stable_first");
    run_period("stable_second", 16'h0005, 16'h0006, 1'b1, 32'h0000001E, 1'b1);

    // Reset mid-operation: get 12 on out, abort the following period at its fifth edge
    run_period("pre_reset", 16'h0003, 16'h0004, 1'b1, 32'h0000000C, 1'b1);
    bus.x = 16'h0005;
    bus.y = 16'h0006;
    for (int e = 1; e <= 4; e++) tick();
    reset = 1'b1;
    tick();
    chk("reset_mid", bus.out, 32'd0);
    reset = 1'b0;
    last_out = 32'd0;
    run_period("post_reset", 16'h0005, 16'h0006, 1'b1, 32'h0000001E, 1'b1);

    // Randomized sweep against the reference product
    for (int i = 0; i < 1000; i++) begin
      run_period($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1'b0, 32'd0, 1'b0);
    end

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
